// File: rtl/pwm_bank.sv
// pwm_bank: NCH phase-aligned PWM channels that share one prescaled WIDTH-bit period counter.
// Each channel has a shadow duty register. Shadow values are copied into the active duty
// registers only at a period wrap, so a duty change never produces a partial period.
// Latency: pwm_out changes one clk after the cnt change that causes it. There is no backpressure.
// Ports: i_clk, i_reset (async, active-high), i_ena, i_prescale, i_duty_in (channel k at
//        [k*WIDTH +: WIDTH]), i_duty_load, i_polarity (1 = active-low), o_pwm_out,
//        o_period_tick, o_update_done.
// Optional feature PWM_FADE_EN: when this macro is defined, active duty steps one LSB per
//        period toward its target instead of jumping to the new value.
module pwm_bank #(
    parameter int NCH        = 3,
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_ena,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic [NCH*WIDTH-1:0]  i_duty_in,
    input  logic                  i_duty_load,
    input  logic [NCH-1:0]        i_polarity,
    output logic [NCH-1:0]        o_pwm_out,
    output logic                  o_period_tick,
    output logic                  o_update_done
);

    logic [PRESCALE_W-1:0]       r_pcnt;
    logic [WIDTH-1:0]            r_cnt;
    logic [NCH-1:0][WIDTH-1:0]   r_shadow;
    logic [NCH-1:0][WIDTH-1:0]   r_active;
    logic                        r_pending;

    logic                        w_tick;
    logic                        w_boundary;
    logic                        w_xfer;
    logic [NCH-1:0]              w_raw;

    assign w_tick     = i_ena && (r_pcnt == i_prescale);
    assign w_boundary = w_tick && (r_cnt == {WIDTH{1'b1}});
    // The transfer reads r_shadow before this cycle's load lands. A load that arrives in
    // the same cycle as the boundary therefore remains pending for the next period.
    assign w_xfer     = w_boundary && r_pending;

    // Prescaler and period counter. The ">=" wraps pcnt immediately when prescale is
    // lowered below the current count.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pcnt <= '0;
            r_cnt  <= '0;
        end else if (!i_ena) begin
            r_pcnt <= '0;
            r_cnt  <= '0;
        end else begin
            if (r_pcnt >= i_prescale) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + PRESCALE_W'(1);
            end
            if (w_tick) begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
        end
    end

    // Shadow capture happens regardless of ena. A load wins over the clear that follows a transfer.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (i_duty_load) begin
                r_shadow  <= i_duty_in;
                r_pending <= 1'b1;
            end else if (w_xfer) begin
                r_pending <= 1'b0;
            end
        end
    end

`ifdef PWM_FADE_EN
    logic [NCH-1:0][WIDTH-1:0]   r_target;
    logic [NCH-1:0][WIDTH-1:0]   w_tgt;
    logic [NCH-1:0][WIDTH-1:0]   w_step;
    logic                        w_moving;
    logic                        w_all_reach;

    // The step at a transfer boundary already heads toward the freshly transferred target.
    always_comb begin
        w_tgt       = r_target;
        w_step      = r_active;
        w_moving    = 1'b0;
        w_all_reach = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            if (w_xfer) begin
                w_tgt[k] = r_shadow[k];
            end
            if (r_active[k] < w_tgt[k]) begin
                w_step[k] = r_active[k] + WIDTH'(1);
            end else if (r_active[k] > w_tgt[k]) begin
                w_step[k] = r_active[k] - WIDTH'(1);
            end
            if (r_active[k] != w_tgt[k]) begin
                w_moving = 1'b1;
            end
            if (w_step[k] != w_tgt[k]) begin
                w_all_reach = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_active      <= '0;
            r_target      <= '0;
            o_update_done <= 1'b0;
        end else begin
            if (w_boundary) begin
                r_active <= w_step;
            end
            if (w_xfer) begin
                r_target <= r_shadow;
            end
            // Pulse once, on the boundary at which the last channel arrives.
            o_update_done <= w_boundary && (r_pending || w_moving) && w_all_reach;
        end
    end
`else
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_active      <= '0;
            o_update_done <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_active <= r_shadow;
            end
            o_update_done <= w_xfer;
        end
    end
`endif

    // An all-ones duty means 100 %. Every other value d is high for d of 2^WIDTH counts.
    always_comb begin
        w_raw = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_active[k] == {WIDTH{1'b1}}) begin
                w_raw[k] = 1'b1;
            end else begin
                w_raw[k] = (r_cnt < r_active[k]);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_pwm_out     <= '0;
            o_period_tick <= 1'b0;
        end else begin
            o_pwm_out     <= i_ena ? (w_raw ^ i_polarity) : i_polarity;
            o_period_tick <= w_boundary;
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: directed test of pwm_bank with hand-computed high-time counts per period.
// Channel 0 = R, 1 = G, 2 = B. Each measurement window starts in the cycle after a
// period_tick and spans one full period, measured in clk cycles.
module tb_pwm_bank;

    localparam int NCH = 3;
    localparam int W   = 8;
    localparam int PW  = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               ena;
    logic [PW-1:0]      prescale;
    logic [NCH*W-1:0]   duty_in;
    logic               duty_load;
    logic [NCH-1:0]     polarity;
    logic [NCH-1:0]     pwm_out;
    logic               period_tick;
    logic               update_done;

    int checks = 0;
    int errors = 0;

    int cyc, ud, anyp, fnd;
    int h0, h1, h2, u, p, lp;

    always #5 clk = ~clk;

    pwm_bank #(.NCH(NCH), .WIDTH(W), .PRESCALE_W(PW)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_ena         (ena),
        .i_prescale    (prescale),
        .i_duty_in     (duty_in),
        .i_duty_load   (duty_load),
        .i_polarity    (polarity),
        .o_pwm_out     (pwm_out),
        .o_period_tick (period_tick),
        .o_update_done (update_done)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Wait for the next period_tick. Returns the number of negedges taken, update_done as
    // sampled on the tick cycle, and an OR of pwm_out over the wait.
    task automatic wait_tick(input int budget, output int n, output int upd,
                             output int any_pwm, output int found);
        n = 0; upd = 0; any_pwm = 0; found = 0;
        while (n < budget && found == 0) begin
            @(negedge clk);
            n++;
            any_pwm = any_pwm | int'(pwm_out);
            if (period_tick) begin
                found = 1;
                upd   = int'(update_done);
            end
        end
    endtask

    task automatic measure(input int n, output int c0, output int c1, output int c2,
                           output int upd, output int pts, output int last_pt);
        c0 = 0; c1 = 0; c2 = 0; upd = 0; pts = 0; last_pt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c0      += int'(pwm_out[0]);
            c1      += int'(pwm_out[1]);
            c2      += int'(pwm_out[2]);
            upd     += int'(update_done);
            pts     += int'(period_tick);
            last_pt  = int'(period_tick);
        end
    endtask

    task automatic load_pulse(input logic [NCH*W-1:0] d);
        duty_in   = d;
        duty_load = 1'b1;
        @(negedge clk);
        duty_load = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got 0 exp 1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        ena       = 1'b1;
        prescale  = '0;
        duty_in   = '0;
        duty_load = 1'b0;
        polarity  = '0;
        repeat (3) @(negedge clk);
        check_val("rst_pwm",  int'(pwm_out), 0);
        check_val("rst_tick", int'(period_tick), 0);
        check_val("rst_upd",  int'(update_done), 0);

`ifdef PWM_FADE_EN
        // R fades 0x00 -> 0x04: one LSB per period, one update_done pulse on arrival.
        reset = 1'b0;
        load_pulse({8'h00, 8'h00, 8'h04});
        wait_tick(600, cyc, ud, anyp, fnd);
        check_val("fade_first_tick", cyc, 255);
        check_val("fade_ud_b1", ud, 0);
        measure(256, h0, h1, h2, u, p, lp);
        check_val("fade_p1_r", h0, 1);
        check_val("fade_p1_ud", u, 0);
        measure(256, h0, h1, h2, u, p, lp);
        check_val("fade_p2_r", h0, 2);
        check_val("fade_p2_ud", u, 0);
        measure(256, h0, h1, h2, u, p, lp);
        check_val("fade_p3_r", h0, 3);
        check_val("fade_p3_ud_b4", u, 1);
        measure(256, h0, h1, h2, u, p, lp);
        check_val("fade_p4_r", h0, 4);
        check_val("fade_p4_ud", u, 0);
        check_val("fade_p4_g", h1, 0);
`else
        // R=0x40 G=0x00 B=0xFF loaded at release: first period stays all-low.
        reset = 1'b0;
        load_pulse({8'hFF, 8'h00, 8'h40});
        wait_tick(600, cyc, ud, anyp, fnd);
        check_val("t1_first_tick", cyc, 255);
        check_val("t1_no_early_pwm", anyp, 0);
        check_val("t1_ud_at_wrap", ud, 1);
        measure(256, h0, h1, h2, u, p, lp);
        check_val("t1_r_high", h0, 64);
        check_val("t1_g_high", h1, 0);
        check_val("t1_b_high", h2, 256);
        check_val("t1_period_end", lp, 1);
        measure(256, h0, h1, h2, u, p, lp);
        check_val("t1_r_high2", h0, 64);
        check_val("t1_no_second_ud", u, 0);

        // prescale = 3, R = 0x80: period is 1024 clk cycles.
        prescale = 4'd3;
        load_pulse({8'hFF, 8'h00, 8'h80});
        wait_tick(3000, cyc, ud, anyp, fnd);
        check_val("t2_found", fnd, 1);
        check_val("t2_ud", ud, 1);
        measure(1024, h0, h1, h2, u, p, lp);
        check_val("t2_r_high", h0, 512);
        check_val("t2_b_high", h2, 1024);
        check_val("t2_tick_count", p, 1);
        check_val("t2_tick_last", lp, 1);

        // Active-low R at 0x40, then ena low.
        prescale = '0;
        polarity = 3'b001;
        load_pulse({8'hFF, 8'h00, 8'h40});
        wait_tick(3000, cyc, ud, anyp, fnd);
        check_val("t3_found", fnd, 1);
        measure(256, h0, h1, h2, u, p, lp);
        check_val("t3_r_inv_high", h0, 192);
        check_val("t3_g_low", h1, 0);
        check_val("t3_b_high", h2, 256);
        ena = 1'b0;
        load_pulse({8'hFF, 8'h00, 8'h60});
        check_val("t3_ena_off_pwm", int'(pwm_out), 1);
        repeat (3) @(negedge clk);
        check_val("t3_ena_off_pwm2", int'(pwm_out), 1);
        check_val("t3_ena_off_tick", int'(period_tick), 0);
        ena = 1'b1;
        wait_tick(600, cyc, ud, anyp, fnd);
        check_val("t3_cnt_restart", cyc, 256);
        check_val("t3_load_while_off", ud, 1);

        // A load that coincides with the boundary: pending 0x20 is used first, then 0x10.
        polarity = 3'b000;
        load_pulse({8'hFF, 8'h00, 8'h20});
        repeat (254) @(negedge clk);
        duty_in   = {8'hFF, 8'h00, 8'h10};
        duty_load = 1'b1;
        @(negedge clk);
        duty_load = 1'b0;
        check_val("t4_tick_align", int'(period_tick), 1);
        check_val("t4_ud_b1", int'(update_done), 1);
        measure(256, h0, h1, h2, u, p, lp);
        check_val("t4_r_0x20", h0, 32);
        check_val("t4_ud_b2", u, 1);
        measure(256, h0, h1, h2, u, p, lp);
        check_val("t4_r_0x10", h0, 16);
        check_val("t4_ud_none", u, 0);

        // Reset asserted at cnt = 0x7A.
        repeat (8'h7A) @(negedge clk);
        check_val("t5_pre_rst_pwm", int'(pwm_out), 4);
        reset = 1'b1;
        #1;
        check_val("t5_async_rst_pwm", int'(pwm_out), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_tick(600, cyc, ud, anyp, fnd);
        check_val("t5_cnt_restart", cyc, 256);
        check_val("t5_no_ud", ud, 0);
        check_val("t5_pwm_idle", anyp, 0);
        measure(256, h0, h1, h2, u, p, lp);
        check_val("t5_r_zero", h0, 0);
        check_val("t5_b_zero", h2, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
